// File: rtl/watchdog_reset_gen_pkg.sv
// watchdog_reset_gen_pkg: register map, bit positions and state encoding for the watchdog reset generator
package watchdog_reset_gen_pkg;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_GRACE  = 8'h0a;
  localparam logic [7:0] ADDR_ACK    = 8'h0b;
  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_WARN_EN     = 1;
  localparam int STATUS_WARN      = 0;
  localparam int STATUS_WD_RST    = 1;
  localparam int STATUS_STATE_LSB = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_RESET = 2'd2
  } wd_state_e;
endpackage

// File: rtl/wd_reset_timer.sv
// wd_reset_timer: 32-bit loadable down-counter that stops at zero
module wd_reset_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] load_val,
  output logic        zero
);
  logic [31:0] cnt;
  // load has priority; counting never wraps below zero
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 32'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/watchdog_reset_gen.sv
// watchdog_reset_gen: turns a watchdog expiry pulse into a warning window and a fixed-width reset request
module watchdog_reset_gen
  import watchdog_reset_gen_pkg::*;
#(
  parameter int          RST_CYCLES    = 16,
  parameter logic [31:0] GRACE_DEFAULT = 32'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  input  logic        expired,
  output logic        warn_irq,
  output logic        sys_reset_req
);
  localparam logic [31:0] RST_LOAD = 32'(RST_CYCLES - 1);
  wd_state_e state, next_state;
  logic ctrl_en, ctrl_warn_en, wd_caused;
  logic [31:0] grace, t_val, status;
  logic wr, wr_ctrl, wr_status, wr_grace, wr_ack;
  logic t_load, t_en, t_zero, enter_reset;
  assign wr        = cs && we;
  assign wr_ctrl   = wr && address == ADDR_CTRL;
  assign wr_status = wr && address == ADDR_STATUS;
  assign wr_grace  = wr && address == ADDR_GRACE;
  assign wr_ack    = wr && address == ADDR_ACK;
  assign ready     = cs;
  wd_reset_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .en       (t_en),
    .load_val (t_val),
    .zero     (t_zero)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= next_state;
  // next state: ACK or disable beats timer expiry in WARN; expiry outside IDLE is dropped
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (expired && ctrl_en) next_state = ctrl_warn_en ? ST_WARN : ST_RESET;
      ST_WARN:  if (wr_ack || (wr_ctrl && !write_data[CTRL_ENABLE])) next_state = ST_IDLE;
                else if (t_zero) next_state = ST_RESET;
      ST_RESET: if (t_zero) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end
  // timer control: reload on entry to WARN or RESET, count down while busy
  always_comb begin
    enter_reset = next_state == ST_RESET && state != ST_RESET;
    t_load      = next_state != state && next_state != ST_IDLE;
    t_val       = next_state == ST_RESET ? RST_LOAD : grace;
    t_en        = state != ST_IDLE;
  end
  // registered outputs track the state being entered so they align with it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      warn_irq      <= 1'b0;
      sys_reset_req <= 1'b0;
    end else begin
      warn_irq      <= next_state == ST_WARN;
      sys_reset_req <= next_state == ST_RESET;
    end
  // software registers; a reset entry sets the sticky flag even against a same-cycle clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ctrl_en      <= 1'b0;
      ctrl_warn_en <= 1'b0;
      grace        <= GRACE_DEFAULT;
      wd_caused    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en      <= write_data[CTRL_ENABLE];
        ctrl_warn_en <= write_data[CTRL_WARN_EN];
      end
      if (wr_grace) grace <= write_data;
      if (enter_reset) wd_caused <= 1'b1;
      else if (wr_status && write_data[STATUS_WD_RST]) wd_caused <= 1'b0;
    end
  // combinational read mux
  always_comb begin
    status                                      = '0;
    status[STATUS_WARN]                         = state == ST_WARN;
    status[STATUS_WD_RST]                       = wd_caused;
    status[STATUS_STATE_LSB+1:STATUS_STATE_LSB] = state;
    read_data = !cs                   ? '0 :
                address == ADDR_CTRL   ? {30'd0, ctrl_warn_en, ctrl_en} :
                address == ADDR_STATUS ? status :
                address == ADDR_GRACE  ? grace : '0;
  end
endmodule

// File: tb/tb_watchdog_reset_gen.sv
// tb_watchdog_reset_gen: directed stimulus against an interval-based model of warning and reset windows
module tb_watchdog_reset_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cs = 1'b0;
  logic we = 1'b0;
  logic expired = 1'b0;
  logic [7:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic ready, warn_irq, sys_reset_req;
  int checks = 0;
  int passed = 0;
  longint cyc = 0;
  longint w_s = -10, w_e = -20, r_s = -10, r_e = -20;
  logic m_en = 1'b0, m_wen = 1'b0, m_sticky = 1'b0;
  logic [31:0] m_grace = 32'd1000;
  watchdog_reset_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cs            (cs),
    .we            (we),
    .address       (address),
    .write_data    (write_data),
    .read_data     (read_data),
    .ready         (ready),
    .expired       (expired),
    .warn_irq      (warn_irq),
    .sys_reset_req (sys_reset_req)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // one clock cycle: check outputs against the window model mid-cycle, then advance the model
  task automatic step();
    logic w, r, wrt;
    logic [1:0] st;
    logic [31:0] exp_rd;
    @(negedge clk);
    if (!reset_n) begin
      w_s = -10; w_e = -20; r_s = -10; r_e = -20;
      m_en = 1'b0; m_wen = 1'b0; m_sticky = 1'b0; m_grace = 32'd1000;
    end
    w  = w_s <= cyc && cyc <= w_e;
    r  = r_s <= cyc && cyc <= r_e;
    st = w ? 2'd1 : r ? 2'd2 : 2'd0;
    exp_rd = !cs ? 32'd0 :
             address == 8'h08 ? {30'd0, m_wen, m_en} :
             address == 8'h09 ? {28'd0, st, m_sticky, w} :
             address == 8'h0a ? m_grace : 32'd0;
    chk("warn_irq", {31'd0, warn_irq}, {31'd0, w});
    chk("sys_reset_req", {31'd0, sys_reset_req}, {31'd0, r});
    chk("read_data", read_data, exp_rd);
    if (reset_n) begin
      wrt = cs && we;
      if (!w && !r && expired && m_en) begin
        if (m_wen) begin
          w_s = cyc + 1;
          w_e = cyc + 1 + longint'(m_grace);
          r_s = w_e + 1;
        end else r_s = cyc + 1;
        r_e = r_s + 15;
      end
      if (w && wrt && (address == 8'h0b || (address == 8'h08 && !write_data[0]))) begin
        w_e = cyc; r_s = -10; r_e = -20;
      end
      if (wrt && address == 8'h09 && write_data[1]) m_sticky = 1'b0;
      if (r_s == cyc + 1) m_sticky = 1'b1;
      if (wrt && address == 8'h08) {m_wen, m_en} = write_data[1:0];
      if (wrt && address == 8'h0a) m_grace = write_data;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [7:0] a, logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask
  task automatic rd(string name, logic [7:0] a, logic [31:0] exp);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    chk(name, read_data, exp);
    chk("ready", {31'd0, ready}, 32'd1);
    step();
    cs = 1'b0;
  endtask
  task automatic pulse();
    expired = 1'b1;
    step();
    expired = 1'b0;
  endtask
  initial begin
    int n;
    step(); step();
    chk("rst_warn", {31'd0, warn_irq}, 32'd0);
    chk("rst_sysrst", {31'd0, sys_reset_req}, 32'd0);
    reset_n = 1'b1;
    step();
    rd("rst_ctrl", 8'h08, 32'd0);
    rd("rst_grace", 8'h0a, 32'd1000);
    rd("rst_status", 8'h09, 32'd0);
    // warning then full reset
    wr(8'h08, 32'd3);
    wr(8'h0a, 32'd5);
    pulse();
    for (int i = 1; i <= 6; i++) begin
      chk("t1_warn", {31'd0, warn_irq}, 32'd1);
      chk("t1_nosys", {31'd0, sys_reset_req}, 32'd0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk("t1_sys", {31'd0, sys_reset_req}, 32'd1);
      chk("t1_nowarn", {31'd0, warn_irq}, 32'd0);
      step();
    end
    chk("t1_sys_end", {31'd0, sys_reset_req}, 32'd0);
    rd("t1_status", 8'h09, 32'd2);
    wr(8'h09, 32'd2);
    // acknowledged warning
    pulse();
    step(); step();
    wr(8'h0b, 32'd0);
    chk("t2_warn_drop", {31'd0, warn_irq}, 32'd0);
    for (int i = 0; i < 25; i++) step();
    rd("t2_status", 8'h09, 32'd0);
    // grace write during WARN applies to the next warning; disable mid-WARN
    pulse();
    wr(8'h0a, 32'd2);
    for (int i = 0; i < 25; i++) step();
    pulse();
    wr(8'h08, 32'd2);
    chk("t2b_disable", {31'd0, warn_irq}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    rd("t2b_ctrl", 8'h08, 32'd2);
    wr(8'h09, 32'd2);
    // immediate reset without warning
    wr(8'h08, 32'd1);
    pulse();
    for (int i = 0; i < 16; i++) begin
      chk("t3_sys", {31'd0, sys_reset_req}, 32'd1);
      chk("t3_nowarn", {31'd0, warn_irq}, 32'd0);
      step();
    end
    chk("t3_sys_end", {31'd0, sys_reset_req}, 32'd0);
    rd("t3_status", 8'h09, 32'd2);
    wr(8'h09, 32'd2);
    rd("t3_cleared", 8'h09, 32'd0);
    // disabled expiry is not latched
    wr(8'h08, 32'd0);
    pulse();
    wr(8'h08, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_quiet", {30'd0, warn_irq, sys_reset_req}, 32'd0);
      step();
    end
    rd("t4_status", 8'h09, 32'd0);
    // zero grace: ACK in the only WARN cycle wins
    wr(8'h08, 32'd3);
    wr(8'h0a, 32'd0);
    pulse();
    chk("t5_warn", {31'd0, warn_irq}, 32'd1);
    wr(8'h0b, 32'd0);
    chk("t5_ack", {30'd0, warn_irq, sys_reset_req}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    rd("t5_status", 8'h09, 32'd0);
    // second expiry during RESET is ignored
    wr(8'h08, 32'd1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      expired = i == 0 || i == 5;
      n += int'(sys_reset_req);
      step();
    end
    expired = 1'b0;
    chk("t5_len", n, 32'd16);
    // power-on reset mid-RESET
    wr(8'h0a, 32'd7);
    pulse();
    for (int i = 0; i < 4; i++) step();
    chk("t6_active", {31'd0, sys_reset_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async", {30'd0, warn_irq, sys_reset_req}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    rd("t6_grace", 8'h0a, 32'd1000);
    rd("t6_status", 8'h09, 32'd0);
    rd("t6_ctrl", 8'h08, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
